rggen_irq_coalescer: RTL and testbench

Interrupt coalescing stage that sits directly downstream of the status and enable bit fields. It takes the status field's `o_value` and the enable field's `o_value`, and counts rising edges of the enabled status bits. It raises a level interrupt once a hold-off time has elapsed or an event-count threshold is reached, whichever comes first. The interrupt drops when software clears all enabled status bits through the bit fields (e.g. W1C).

---
 rtl/rggen_irq_coalescer.sv | 148 ++++++++++++++
 tb/tb_rggen_irq_coalescer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescer for rggen status/enable fields: counts rising edges of
// enabled status bits and raises a level IRQ after a hold-off or a count threshold.

module rggen_irq_coalescer_lane (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_status,
  input  logic i_enable,
  output logic o_active_q,
  output logic o_rise
);
  logic active;
  logic active_q;

  assign active = i_status & i_enable;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) active_q <= 1'b0;
    else          active_q <= active;
  end

  // Enabling a bit whose status is already set also shows up as a rise here.
  assign o_rise     = active & ~active_q;
  assign o_active_q = active_q;
endmodule

module rggen_irq_coalescer #(
  parameter int WIDTH         = 8,
  parameter int HOLDOFF_WIDTH = 8,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [WIDTH-1:0]         i_status,
  input  logic [WIDTH-1:0]         i_enable,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic [COUNT_WIDTH-1:0]   i_threshold,
  output logic                     o_irq,
  output logic [WIDTH-1:0]         o_pending,
  output logic [COUNT_WIDTH-1:0]   o_event_count
);
  localparam int INC_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((COUNT_WIDTH > INC_W) ? COUNT_WIDTH : INC_W) + 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONES = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COALESCE = 2'd1,
    ASSERT   = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [HOLDOFF_WIDTH-1:0] timer_q, timer_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;

  logic [WIDTH-1:0]       active;
  logic [WIDTH-1:0]       active_q;
  logic [WIDTH-1:0]       rise;
  logic                   any_active;
  logic [INC_W-1:0]       inc;
  logic [SUM_W-1:0]       sum;
  logic [COUNT_WIDTH-1:0] next_count;
  logic                   count_hit;

  assign active     = i_status & i_enable;
  assign any_active = |active;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    rggen_irq_coalescer_lane u_lane (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_status   (i_status[g]),
      .i_enable   (i_enable[g]),
      .o_active_q (active_q[g]),
      .o_rise     (rise[g])
    );
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < WIDTH; i++) inc = inc + INC_W'(rise[i]);
  end

  // Sum is widened so a multi-bit rise can never wrap before the clamp.
  assign sum        = SUM_W'(count_q) + SUM_W'(inc);
  assign next_count = (sum > SUM_W'(CNT_ONES)) ? CNT_ONES : sum[COUNT_WIDTH-1:0];
  assign count_hit  = (i_threshold != '0) && (next_count >= i_threshold);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (!any_active) begin
          count_d = '0;
        end else begin
          count_d = next_count;
          if ((i_holdoff == '0) || count_hit) begin
            state_d = ASSERT;
          end else begin
            state_d = COALESCE;
            timer_d = i_holdoff;
          end
        end
      end
      COALESCE: begin
        // Episode cancelled by software before the IRQ ever fired.
        if (!any_active) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = next_count;
          if ((timer_q == HOLDOFF_WIDTH'(1)) || count_hit) state_d = ASSERT;
          else                                               timer_d = timer_q - HOLDOFF_WIDTH'(1);
        end
      end
      ASSERT: begin
        if (!any_active) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = next_count;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign o_irq         = (state_q == ASSERT);
  assign o_pending     = active_q;
  assign o_event_count = count_q;
endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Scoreboard bench for rggen_irq_coalescer: a cycle-level behavioural model
// pushes expected outputs, a monitor pops and compares every clock.

module tb_rggen_irq_coalescer;
  localparam int W    = 8;
  localparam int HW   = 8;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [W-1:0]  i_status, i_enable;
  logic [HW-1:0] i_holdoff;
  logic [CW-1:0] i_threshold;
  logic          o_irq;
  logic [W-1:0]  o_pending;
  logic [CW-1:0] o_event_count;

  always #5 i_clk = ~i_clk;

  rggen_irq_coalescer #(.WIDTH(W), .HOLDOFF_WIDTH(HW), .COUNT_WIDTH(CW)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_status      (i_status),
    .i_enable      (i_enable),
    .i_holdoff     (i_holdoff),
    .i_threshold   (i_threshold),
    .o_irq         (o_irq),
    .o_pending     (o_pending),
    .o_event_count (o_event_count)
  );

  typedef struct {
    logic          irq;
    logic [W-1:0]  pend;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model: an episode starts when anything becomes active; the IRQ fires at a
  // fixed deadline cycle or earlier on the threshold, and ends when nothing is active.
  bit           m_ep, m_irq;
  int           m_deadline, m_cnt, cyc;
  logic [W-1:0] m_prev;

  function automatic int popc(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ep = 0; m_irq = 0; m_cnt = 0; m_prev = '0; m_deadline = 0;
  endtask

  task automatic step(input logic [W-1:0] st, input logic [W-1:0] en,
                      input logic [HW-1:0] ho, input logic [CW-1:0] th);
    logic [W-1:0] act;
    bit hit;
    exp_t e;
    @(posedge i_clk); #3;
    i_status = st; i_enable = en; i_holdoff = ho; i_threshold = th;
    cyc++;
    act = st & en;
    if (act == '0) begin
      m_ep = 0; m_irq = 0; m_cnt = 0;
    end else begin
      m_cnt = m_cnt + popc(act & ~m_prev);
      if (m_cnt > CMAX) m_cnt = CMAX;
      hit = (th != 0) && (m_cnt >= int'(th));
      if (!m_ep) begin
        m_ep = 1;
        if (ho == 0 || hit) m_irq = 1;
        else m_deadline = cyc + int'(ho) + 1;
      end else if (!m_irq && (cyc + 1 == m_deadline || hit)) begin
        m_irq = 1;
      end
    end
    m_prev = act;
    e.irq = m_irq; e.pend = act; e.cnt = CW'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(i_status, i_enable, i_holdoff, i_threshold);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic mid_reset();
    @(posedge i_clk); #3;
    i_rst_n = 1'b0;
    #1;
    n_vec++;
    chk("rst_irq", int'(o_irq), 0);
    chk("rst_pending", int'(o_pending), 0);
    chk("rst_count", int'(o_event_count), 0);
    i_status = '0; i_enable = '0;
    model_reset();
    @(posedge i_clk); #3;
    i_rst_n = 1'b1;
  endtask

  always @(posedge i_clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      chk("irq", int'(o_irq), int'(e.irq));
      chk("pending", int'(o_pending), int'(e.pend));
      chk("event_count", int'(o_event_count), int'(e.cnt));
    end
  end

  initial begin
    logic [W-1:0]  st, en;
    logic [HW-1:0] ho;
    logic [CW-1:0] th;
    int r;
    i_rst_n = 1'b0; i_status = '0; i_enable = '0; i_holdoff = '0; i_threshold = '0;
    model_reset(); cyc = 0;
    #12;
    n_vec++;
    chk("init_irq", int'(o_irq), 0);
    chk("init_pending", int'(o_pending), 0);
    chk("init_count", int'(o_event_count), 0);
    #11 i_rst_n = 1'b1;

    // Immediate interrupt, then release.
    step(8'h01, 8'h01, 0, 0); hold(3);
    step(8'h00, 8'h01, 0, 0); hold(2);
    // Hold-off expiry at n+5.
    step(8'h01, 8'h01, 4, 0); hold(6);
    step(8'h00, 8'h01, 4, 0); hold(1);
    // Count trigger beats a long timer.
    step(8'h01, 8'h07, 100, 3); hold(1);
    step(8'h03, 8'h07, 100, 3); hold(2);
    step(8'h07, 8'h07, 100, 3); hold(3);
    step(8'h00, 8'h07, 100, 3); hold(1);
    // Cancelled episode.
    step(8'h04, 8'hFF, 10, 0); hold(2);
    step(8'h00, 8'hFF, 10, 0); hold(12);
    // Multi-bit rise and saturation.
    step(8'h0F, 8'hFF, 50, 0);
    step(8'hFF, 8'hFF, 50, 0);
    step(8'h7F, 8'hFF, 50, 0);
    step(8'hFF, 8'hFF, 50, 0); hold(1);
    step(8'h00, 8'hFF, 50, 0); hold(1);
    // Enable gating: one event from enabling an already-set bit, then reset.
    step(8'hFF, 8'h00, 0, 0); hold(1);
    step(8'hFF, 8'h10, 0, 0); hold(3);
    mid_reset();
    hold(2);

    st = '0; en = 8'hFF; ho = 3; th = 0;
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 9);
      if (r == 5 || r == 6 || r == 7) st[$urandom_range(0, W-1)] ^= 1'b1;
      else if (r == 8) st = '0;
      else if (r == 9) st = W'($urandom);
      if ($urandom_range(0, 15) == 0) en = W'($urandom);
      if ($urandom_range(0, 7) == 0) ho = HW'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) th = CW'($urandom_range(0, 5));
      step(st, en, ho, th);
      if (k == 1500) begin
        mid_reset();
        st = '0;
      end
    end
    hold(2);
    @(posedge i_clk); #3;
    n_vec++;
    chk("scoreboard_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
